scr_arbiter: RTL and testbench

SCR_ARBITER -- requirements
Module: scr_arbiter

---
 rtl/scr_arb_pkg.sv | 15 +
 rtl/scr_arb_starve_cnt.sv | 34 +++
 rtl/scr_arbiter.sv | 79 +++++++
 tb/tb_scr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/scr_arb_pkg.sv
// Shared types and default sizing for the scratch RAM arbiter.
// Holds the arbitration state enum and the starve counter width.
package scr_arb_pkg;

    typedef enum logic {
        ARB_CPU   = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_DATA_W       = 10;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_W            = 4;

endpackage

// File: rtl/scr_arb_starve_cnt.sv
// Counts consecutive denied DMA cycles, saturating at LIMIT.
// The limit flag fires in the cycle whose edge brings the count to LIMIT.
module scr_arb_starve_cnt
    import scr_arb_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic limit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;
    logic             starved;

    assign starved = dma_req && !dma_gnt;
    assign limit   = starved && (count == LIM - 1'b1);

    // A grant or a dropped request both end the starvation streak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!starved) begin
            count <= '0;
        end else if (count != LIM) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/scr_arbiter.sv
// Scratch RAM arbiter: CPU has priority, DMA gets a forced grant after
// STARVE_LIMIT consecutive denied cycles. RAM read is asynchronous.
module scr_arbiter
    import scr_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_e state;
    logic       cpu_win;
    logic       dma_win;
    logic       starve_hit;

    always_comb begin
        dma_win = dma_req && (state == ARB_FORCE || !cpu_req);
        cpu_win = cpu_req && !dma_win;
    end

    assign cpu_stall = cpu_req && !cpu_win;
    assign dma_gnt   = dma_win;

    // With no grant the CPU side still drives address/data, write held off.
    assign ram_we    = dma_win ? dma_we    : (cpu_win && cpu_we);
    assign ram_addr  = dma_win ? dma_addr  : cpu_addr;
    assign ram_din   = dma_win ? dma_wdata : cpu_wdata;
    assign cpu_rdata = ram_dout;

    scr_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .dma_req (dma_req),
        .dma_gnt (dma_win),
        .limit   (starve_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_CPU;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_win && !dma_we;
            if (dma_win && !dma_we) begin
                dma_rdata <= ram_dout;
            end
            // Forced priority lasts one cycle: it either grants or finds no request.
            case (state)
                ARB_CPU:   if (starve_hit) state <= ARB_FORCE;
                ARB_FORCE: state <= ARB_CPU;
                default:   state <= ARB_CPU;
            endcase
        end
    end

endmodule

// File: tb/tb_scr_arbiter.sv
// Scoreboard bench for scr_arbiter: stimulus pushes expectations from a
// rule-level model, a negedge monitor pops and compares.
module tb_scr_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 10;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] mem [0:255];

    scr_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

    typedef struct packed {
        logic          stall;
        logic          gnt;
        logic          we;
        logic          rvalid;
        logic          creq;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] cdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    // Reference model: memory image, denied-cycle streak, pending read result.
    logic [DW-1:0] ref_mem [0:255];
    int            waited;
    bit            rv;
    logic [DW-1:0] rdat;
    bit            last_gnt, last_stall;

    task automatic step();
        exp_t e;
        logic dwin, cwin;
        if (rst) begin
            waited = 0; rv = 1'b0; rdat = '0;
        end
        dwin     = dma_req && (waited == LIMIT || !cpu_req);
        cwin     = cpu_req && !dwin;
        e.stall  = cpu_req && !cwin;
        e.gnt    = dwin;
        e.we     = dwin ? dma_we : (cwin && cpu_we);
        e.addr   = dwin ? dma_addr : cpu_addr;
        e.din    = dwin ? dma_wdata : cpu_wdata;
        e.cdata  = ref_mem[e.addr];
        e.rvalid = rv;
        e.rdata  = rdat;
        e.creq   = cpu_req;
        q.push_back(e);
        if (e.we) ref_mem[e.addr] = e.din;
        last_gnt   = dwin;
        last_stall = e.stall;
        if (!rst) begin
            rv = dwin && !dma_we;
            if (rv) rdat = e.cdata;
            if (dwin || !dma_req) waited = 0;
            else if (waited < LIMIT) waited = waited + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic rand_cycle();
        if (!last_stall) begin
            cpu_req   = ($urandom_range(0, 99) < 60);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = AW'($urandom_range(0, 15));
            cpu_wdata = DW'($urandom);
        end
        if (!(dma_req && !last_gnt)) begin
            dma_req   = ($urandom_range(0, 99) < 45);
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = AW'($urandom_range(0, 15));
            dma_wdata = DW'($urandom);
        end
        rst = ($urandom_range(0, 79) == 0);
        step();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stimulus
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        waited = 0; rv = 1'b0; rdat = '0; last_gnt = 1'b0; last_stall = 1'b0;
        rst = 1'b1;
        set(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000);
        @(posedge clk);
        #1;
        step(); step();
        rst = 1'b0;

        // Idle CPU, DMA write then read back
        set(0, 0, 8'h00, 10'h000, 1, 1, 8'h10, 10'h2A5); step();
        set(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000); step();
        set(0, 0, 8'h00, 10'h000, 1, 0, 8'h10, 10'h000); step();
        set(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000); step(); step();

        // CPU write then read-after-write at the top address
        set(1, 1, 8'hFF, 10'h3FF, 0, 0, 8'h00, 10'h000); step();
        set(1, 0, 8'hFF, 10'h000, 0, 0, 8'h00, 10'h000); step();

        // Sustained contention
        set(1, 0, 8'h20, 10'h000, 1, 1, 8'h30, 10'h155);
        for (int i = 0; i < 20; i++) step();
        set(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000); step();

        // Reset during the forced cycle
        set(1, 0, 8'h21, 10'h000, 1, 0, 8'h31, 10'h000);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        set(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000); step();

        // Dropped request restarts the starve count
        set(1, 0, 8'h22, 10'h000, 1, 1, 8'h32, 10'h0AA);
        for (int i = 0; i < 3; i++) step();
        dma_req = 1'b0; step();
        dma_req = 1'b1;
        for (int i = 0; i < 5; i++) step();
        set(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000); step();

        for (int i = 0; i < 400; i++) rand_cycle();
        rst = 1'b0;
        set(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000);
        step(); step(); step();
        done = 1'b1;
    end

    // Monitor
    initial begin
        exp_t e;
        logic pg, pc;
        pg = 1'b0;
        pc = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cpu_stall",  32'(cpu_stall),  32'(e.stall));
                chk("dma_gnt",    32'(dma_gnt),    32'(e.gnt));
                chk("ram_we",     32'(ram_we),     32'(e.we));
                chk("ram_addr",   32'(ram_addr),   32'(e.addr));
                chk("ram_din",    32'(ram_din),    32'(e.din));
                chk("cpu_rdata",  32'(cpu_rdata),  32'(e.cdata));
                chk("dma_rvalid", 32'(dma_rvalid), 32'(e.rvalid));
                chk("dma_rdata",  32'(dma_rdata),  32'(e.rdata));
                if (cpu_req && pc) begin
                    chk("dma_b2b_grant", 32'(dma_gnt && pg), 32'd0);
                end
                pg = dma_gnt;
                pc = cpu_req;
            end
            if (done && q.size() == 0) break;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d expectations left", q.size());
        $fatal(1, "watchdog expired");
    end

endmodule
